// File: rtl/data_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : data_mem_responder                                           |
// | Description : Data-memory slave for the MEM stage of the pipelined core.   |
// |               Word RAM with a fixed access latency of WAIT_CYCLES+1 cycles |
// |               after accept. It stalls the pipeline while an access is in   |
// |               flight, returns load data with a one-cycle valid strobe and  |
// |               flags illegal accesses with a one-cycle error strobe.        |
// | Ports       : clk        - clock, all state updates on posedge             |
// |               rst        - synchronous reset, active-high                  |
// |               mem_read   - load request                                    |
// |               mem_write  - store request                                   |
// |               addr[31:0] - byte address                                    |
// |               wdata[31:0]- store data                                      |
// |               rdata[31:0]- load data, registered, held between loads       |
// |               rvalid     - pulse in DONE: rdata updated by a legal load    |
// |               stall      - hold pipeline, (IDLE & req) | WAIT              |
// |               err        - pulse in DONE: access was illegal               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2,
   parameter int ADDR_W      = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        rvalid,
   output logic        stall,
   output logic        err
);

   // Counter only needs to reach WAIT_CYCLES; keep at least one bit so the
   // zero-wait configuration still elaborates.
   localparam int C_CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [C_CNT_W-1:0] C_CNT_MAX   = C_CNT_W'(WAIT_CYCLES);
   localparam logic [32:0]        C_BYTE_LIM  = 33'(DEPTH_WORDS) << 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic [C_CNT_W-1:0]   r_cnt;
   logic [C_CNT_W-1:0]   w_cnt_next;

   // Request captured at accept time; serviced regardless of later inputs.
   logic                 r_op_read;
   logic                 r_op_write;
   logic                 r_illegal;
   logic [ADDR_W-1:0]    r_word;
   logic [31:0]          r_wdata;

   logic [31:0]          r_rdata;
   logic                 r_rvalid;
   logic                 r_err;
   logic [31:0]          r_mem [DEPTH_WORDS];

   logic                 w_req;
   logic                 w_req_illegal;
   logic                 w_idle;
   logic                 w_cur_read;
   logic                 w_cur_write;
   logic                 w_cur_illegal;
   logic [ADDR_W-1:0]    w_cur_word;
   logic [31:0]          w_cur_wdata;
   logic                 w_commit;
   logic                 w_commit_write;
   logic                 w_commit_read;

   assign w_req         = mem_read | mem_write;
   assign w_req_illegal = (addr[1:0] != 2'b00)
                        | ({1'b0, addr} >= C_BYTE_LIM)
                        | (mem_read & mem_write);
   assign w_idle        = (r_state == S_IDLE);

   // With WAIT_CYCLES=0 the edge entering DONE is the accept edge itself, so
   // the committing access must come straight from the inputs in that case.
   assign w_cur_read    = w_idle ? mem_read                 : r_op_read;
   assign w_cur_write   = w_idle ? mem_write                : r_op_write;
   assign w_cur_illegal = w_idle ? w_req_illegal            : r_illegal;
   assign w_cur_word    = w_idle ? addr[ADDR_W+1:2]         : r_word;
   assign w_cur_wdata   = w_idle ? wdata                    : r_wdata;

   // DONE is never followed by DONE, so the transition into it is unique.
   assign w_commit       = (w_next_state == S_DONE);
   assign w_commit_write = w_commit & w_cur_write & ~w_cur_illegal;
   assign w_commit_read  = w_commit & w_cur_read  & ~w_cur_illegal;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_cnt_next;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_cnt_next   = r_cnt;
      stall        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_req) begin
               stall        = 1'b1;
               w_next_state = (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
               w_cnt_next   = C_CNT_W'(1);
            end
         end
         S_WAIT: begin
            stall = 1'b1;
            if (r_cnt == C_CNT_MAX) begin
               w_next_state = S_DONE;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next   = r_cnt + C_CNT_W'(1);
            end
         end
         S_DONE: begin
            w_next_state = S_IDLE;
            w_cnt_next   = '0;
         end
         default: begin
            w_next_state = S_IDLE;
            w_cnt_next   = '0;
         end
      endcase
   end

   // ------------------------------------------------------ request latch
   always_ff @(posedge clk) begin
      if (rst) begin
         r_op_read  <= 1'b0;
         r_op_write <= 1'b0;
         r_illegal  <= 1'b0;
         r_word     <= '0;
         r_wdata    <= '0;
      end else if (w_idle && w_req) begin
         r_op_read  <= mem_read;
         r_op_write <= mem_write;
         r_illegal  <= w_req_illegal;
         r_word     <= addr[ADDR_W+1:2];
         r_wdata    <= wdata;
      end
   end

   // ------------------------------------------------- completion outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_rvalid <= w_commit_read;
         r_err    <= w_commit & w_cur_illegal;
         if (w_commit_read) begin
            r_rdata <= r_mem[w_cur_word];
         end
      end
   end

   // RAM contents survive reset; an uncommitted store is dropped because the
   // reset cycle suppresses the write.
   always_ff @(posedge clk) begin
      if (!rst && w_commit_write) begin
         r_mem[w_cur_word] <= w_cur_wdata;
      end
   end

   assign rdata  = r_rdata;
   assign rvalid = r_rvalid;
   assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_data_mem_responder                                        |
// | Description : Self-checking bench for data_mem_responder. One instance     |
// |               with WAIT_CYCLES=2 driven from a vector table plus a reset   |
// |               sequence, one with WAIT_CYCLES=0 for a full-range sweep.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        rd0 = 1'b0, wr0 = 1'b0;
   logic [31:0] addr0 = '0, wdata0 = '0;
   logic [31:0] rdata0;
   logic        rvalid0, stall0, err0;

   logic        rd1 = 1'b0, wr1 = 1'b0;
   logic [31:0] addr1 = '0, wdata1 = '0;
   logic [31:0] rdata1;
   logic        rvalid1, stall1, err1;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .ADDR_W(8)) dut0 (
      .clk(clk), .rst(rst), .mem_read(rd0), .mem_write(wr0),
      .addr(addr0), .wdata(wdata0), .rdata(rdata0), .rvalid(rvalid0),
      .stall(stall0), .err(err0)
   );

   data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .ADDR_W(8)) dut1 (
      .clk(clk), .rst(rst), .mem_read(rd1), .mem_write(wr1),
      .addr(addr1), .wdata(wdata1), .rdata(rdata1), .rvalid(rvalid1),
      .stall(stall1), .err(err1)
   );

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_stall;
      logic        exp_rvalid;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input int idx,
                        input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
      end
   endtask

   function automatic void push(input logic rd, input logic wr,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic st, input logic rv, input logic er,
                                input logic [31:0] rdat);
      vec_t v;
      v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd;
      v.exp_stall = st; v.exp_rvalid = rv; v.exp_err = er; v.exp_rdata = rdat;
      vecs.push_back(v);
   endfunction

   // One full access at WAIT_CYCLES=2: accept cycle + two WAIT cycles with
   // stall high, then DONE with the strobes. Inputs are held through DONE.
   function automatic void acc(input logic rd, input logic wr,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] rd_before,
                               input logic [31:0] rd_after,
                               input logic rv, input logic er);
      for (int k = 0; k < 3; k++) push(rd, wr, a, wd, 1'b1, 1'b0, 1'b0, rd_before);
      push(rd, wr, a, wd, 1'b0, rv, er, rd_after);
   endfunction

   function automatic void idle(input logic [31:0] rdat);
      push(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, rdat);
   endfunction

   function automatic logic [31:0] pat(input int i);
      logic [31:0] p;
      p = (32'h9E3779B9 * 32'(i + 1)) ^ 32'(i);
      return p;
   endfunction

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // ---------------------------------------------------------- table
      idle(32'h0);                                                          // reset state
      acc(1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 1'b0);
      acc(1'b1, 1'b0, 32'h10,  32'h0,        32'h0, 32'hDEADBEEF, 1'b1, 1'b0);
      idle(32'hDEADBEEF);
      acc(1'b1, 1'b0, 32'h13,  32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1);
      acc(1'b1, 1'b0, 32'h400, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1);
      acc(1'b0, 1'b1, 32'h20,  32'h55667788, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0);
      acc(1'b1, 1'b1, 32'h20,  32'h00001234, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1);
      acc(1'b1, 1'b0, 32'h20,  32'h0, 32'hDEADBEEF, 32'h55667788, 1'b1, 1'b0);
      acc(1'b0, 1'b1, 32'h0,   32'hCAFEF00D, 32'h55667788, 32'h55667788, 1'b0, 1'b0);
      acc(1'b0, 1'b1, 32'h400, 32'h00000BAD, 32'h55667788, 32'h55667788, 1'b0, 1'b1);
      acc(1'b0, 1'b1, 32'h12,  32'h0BADBAD0, 32'h55667788, 32'h55667788, 1'b0, 1'b1);
      acc(1'b1, 1'b0, 32'h0,   32'h0, 32'h55667788, 32'hCAFEF00D, 1'b1, 1'b0);
      acc(1'b1, 1'b0, 32'h10,  32'h0, 32'hCAFEF00D, 32'hDEADBEEF, 1'b1, 1'b0);
      acc(1'b0, 1'b1, 32'h3FC, 32'h13579BDF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0);
      acc(1'b1, 1'b0, 32'h3FC, 32'h0, 32'hDEADBEEF, 32'h13579BDF, 1'b1, 1'b0);
      idle(32'h13579BDF);
      acc(1'b0, 1'b1, 32'h30,  32'hAAAA0000, 32'h13579BDF, 32'h13579BDF, 1'b0, 1'b0);
      idle(32'h13579BDF);

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         rd0 = vecs[i].rd; wr0 = vecs[i].wr;
         addr0 = vecs[i].addr; wdata0 = vecs[i].wdata;
         @(negedge clk);
         check("stall",  i, {31'b0, stall0},  {31'b0, vecs[i].exp_stall});
         check("rvalid", i, {31'b0, rvalid0}, {31'b0, vecs[i].exp_rvalid});
         check("err",    i, {31'b0, err0},    {31'b0, vecs[i].exp_err});
         check("rdata",  i, rdata0,           vecs[i].exp_rdata);
         next_cycle();
      end

      // ------------------------------------ reset during first WAIT cycle
      rd0 = 1'b0; wr0 = 1'b1; addr0 = 32'h30; wdata0 = 32'hA5A5A5A5;
      @(negedge clk);
      check("rst_seq accept stall", 0, {31'b0, stall0}, 32'h1);
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      check("rst_seq wait stall", 1, {31'b0, stall0}, 32'h1);
      next_cycle();
      rst = 1'b0; wr0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
      @(negedge clk);
      check("rst_seq idle stall",  2, {31'b0, stall0},  32'h0);
      check("rst_seq idle rvalid", 2, {31'b0, rvalid0}, 32'h0);
      check("rst_seq idle err",    2, {31'b0, err0},    32'h0);
      check("rst_seq rdata reset", 2, rdata0,           32'h0);
      next_cycle();
      // Idle with no request must stay unstalled and quiet.
      @(negedge clk);
      check("rst_seq quiet stall", 3, {31'b0, stall0}, 32'h0);
      next_cycle();
      rd0 = 1'b1; addr0 = 32'h30;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("rst_seq load stall",  4 + k, {31'b0, stall0},  (k < 3) ? 32'h1 : 32'h0);
         check("rst_seq load rvalid", 4 + k, {31'b0, rvalid0}, (k == 3) ? 32'h1 : 32'h0);
         next_cycle();
      end
      check("rst_seq old data kept", 8, rdata0, 32'hAAAA0000);
      rd0 = 1'b0; addr0 = 32'h0;
      @(negedge clk);
      check("rst_seq rvalid one cycle", 9, {31'b0, rvalid0}, 32'h0);
      check("rst_seq rdata held",       9, rdata0,           32'hAAAA0000);
      next_cycle();

      // ------------------------------------------ zero-wait full sweep
      for (int i = 0; i < 256; i++) begin
         wr1 = 1'b1; rd1 = 1'b0; addr1 = 32'(i * 4); wdata1 = pat(i);
         @(negedge clk);
         check("w0 store stall", i, {31'b0, stall1}, 32'h1);
         next_cycle();
         @(negedge clk);
         check("w0 store done stall",  i, {31'b0, stall1},  32'h0);
         check("w0 store done rvalid", i, {31'b0, rvalid1}, 32'h0);
         check("w0 store done err",    i, {31'b0, err1},    32'h0);
         next_cycle();
         wr1 = 1'b0; rd1 = 1'b1; wdata1 = 32'h0;
         @(negedge clk);
         check("w0 load stall", i, {31'b0, stall1}, 32'h1);
         next_cycle();
         @(negedge clk);
         check("w0 load done stall",  i, {31'b0, stall1},  32'h0);
         check("w0 load done rvalid", i, {31'b0, rvalid1}, 32'h1);
         check("w0 load data",        i, rdata1,           pat(i));
         next_cycle();
      end
      rd1 = 1'b0; addr1 = 32'h0;
      @(negedge clk);
      check("w0 final rvalid", 0, {31'b0, rvalid1}, 32'h0);
      check("w0 final rdata",  0, rdata1,           pat(255));
      next_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
